uart_tx: RTL

- Transmit-side serializer; sits directly upstream of the UART receiver and drives its serial input line.
- Accepts one byte per valid/ready handshake and emits the frame the receiver expects: start bit (0), even-parity bit, 8 data bits LSB-first, stop bit (1).
- Then holds the line idle for a guard period so the receiver's hold/idle sequence completes before the next start edge.

---
 rtl/uart_tx.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmit serializer: start, even parity, 8 data bits LSB-first, stop, then idle guard.
// Optional build macro UART_TX_PARITY_INJECT_EN adds i_injectParityErr to invert one frame's parity.
module uart_tx #(
    parameter int unsigned clksPerBit = 16,
    parameter int unsigned guardClks  = clksPerBit / 2 + 4
) (
    input  logic       i_clkTx,
    input  logic       i_rstN,
    input  logic       i_txValid,
`ifdef UART_TX_PARITY_INJECT_EN
    input  logic       i_injectParityErr,
`endif
    input  logic [7:0] i_txByte,
    output logic       o_txReady,
    output logic       o_txBit,
    output logic       o_txBusy,
    output logic       o_txDone
);

    typedef enum logic [2:0] {
        s_idleTx   = 3'd0,
        s_startTx  = 3'd1,
        s_parityTx = 3'd2,
        s_dataTx   = 3'd3,
        s_stopTx   = 3'd4,
        s_guardTx  = 3'd5
    } tx_state_e;

    localparam logic [7:0] BitLast   = 8'(clksPerBit - 1);
    localparam logic [7:0] GuardLast = (guardClks == 0) ? 8'd0 : 8'(guardClks - 1);
    localparam bit         HasGuard  = (guardClks != 0);

    tx_state_e  state_q, state_d;
    logic [7:0] clk_cnt_q, clk_cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic       parity_q, parity_d;
    logic       tx_bit_q, tx_bit_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       ready_q, ready_d;
    logic       inject;
    logic       bit_end;

`ifdef UART_TX_PARITY_INJECT_EN
    assign inject = i_injectParityErr;
`else
    assign inject = 1'b0;
`endif

    assign bit_end = (clk_cnt_q == BitLast);

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tx_bit_d  = tx_bit_q;
        busy_d    = busy_q;
        ready_d   = ready_q;
        done_d    = 1'b0;

        case (state_q)
            s_idleTx: begin
                tx_bit_d = 1'b1;
                busy_d   = 1'b0;
                ready_d  = 1'b1;
                if (i_txValid && ready_q) begin
                    state_d   = s_startTx;
                    shift_d   = i_txByte;
                    parity_d  = (^i_txByte) ^ inject;
                    clk_cnt_d = 8'd0;
                    bit_idx_d = 3'd0;
                    tx_bit_d  = 1'b0;
                    busy_d    = 1'b1;
                    ready_d   = 1'b0;
                end
            end
            s_startTx: begin
                if (bit_end) begin
                    clk_cnt_d = 8'd0;
                    state_d   = s_parityTx;
                    tx_bit_d  = parity_q;
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            s_parityTx: begin
                if (bit_end) begin
                    clk_cnt_d = 8'd0;
                    bit_idx_d = 3'd0;
                    state_d   = s_dataTx;
                    tx_bit_d  = shift_q[0];
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            s_dataTx: begin
                if (bit_end) begin
                    clk_cnt_d = 8'd0;
                    shift_d   = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d  = s_stopTx;
                        tx_bit_d = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        // Next bit is the one about to shift into position 0.
                        tx_bit_d  = shift_q[1];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            s_stopTx: begin
                tx_bit_d = 1'b1;
                if (bit_end) begin
                    clk_cnt_d = 8'd0;
                    if (HasGuard) begin
                        state_d = s_guardTx;
                    end else begin
                        state_d = s_idleTx;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            s_guardTx: begin
                tx_bit_d = 1'b1;
                if (clk_cnt_q == GuardLast) begin
                    clk_cnt_d = 8'd0;
                    state_d   = s_idleTx;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    ready_d   = 1'b1;
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d   = s_idleTx;
                clk_cnt_d = 8'd0;
                bit_idx_d = 3'd0;
                tx_bit_d  = 1'b1;
                busy_d    = 1'b0;
                ready_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clkTx or negedge i_rstN) begin
        if (!i_rstN) begin
            state_q   <= s_idleTx;
            clk_cnt_q <= 8'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            parity_q  <= 1'b0;
            tx_bit_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_bit_q  <= tx_bit_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    assign o_txReady = ready_q;
    assign o_txBit   = tx_bit_q;
    assign o_txBusy  = busy_q;
    assign o_txDone  = done_q;

`ifndef SYNTHESIS
    a_ready_not_busy: assert property (@(posedge i_clkTx) disable iff (!i_rstN)
        !(ready_q && busy_q));
    a_done_single: assert property (@(posedge i_clkTx) disable iff (!i_rstN)
        done_q |=> !done_q);
`endif

endmodule
